ctrl_seq: RTL and testbench

//   Fetch/execute sequencer sitting directly upstream of the ALU/accumulator datapath.

---
 rtl/alu_pkg.sv | 10 +
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_seq_if.sv | 24 ++
 rtl/ctrl_decode.sv | 36 +++
 rtl/ctrl_seq.sv | 77 +++++++
 tb/tb_ctrl_seq.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes shared by the ALU and its sequencer
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_LD  = 3'd6;
endpackage

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, sequencer states and jump kinds for ctrl_seq
package ctrl_pkg;
    localparam int INSTR_W = 12;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBC  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_RSVD_D = 4'hD;
    localparam logic [3:0] OP_RSVD_E = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;
    typedef enum logic [1:0] {J_NONE, J_ALWAYS, J_CARRY, J_ZERO} jump_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[11:8];
    endfunction
endpackage

// File: rtl/ctrl_seq_if.sv
// rtl/ctrl_seq_if.sv - sequencer <-> ROM/ALU/accumulator signal bundle
interface ctrl_seq_if import ctrl_pkg::*; #(parameter int PC_W = 8) ();
    logic               Stall;
    logic [INSTR_W-1:0] Instr;
    logic               CY;
    logic               A_zero;
    logic [PC_W-1:0]    PC;
    logic [2:0]         ALUCode;
    logic [7:0]         R;
    logic               Ci;
    logic               A_CE;
    logic               CY_CE;
    logic               Halted;

    modport master (
        input  Stall, Instr, CY, A_zero,
        output PC, ALUCode, R, Ci, A_CE, CY_CE, Halted
    );

    modport slave (
        output Stall, Instr, CY, A_zero,
        input  PC, ALUCode, R, Ci, A_CE, CY_CE, Halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode into ALU controls and jump kind
module ctrl_decode import ctrl_pkg::*, alu_pkg::*; (
    input  logic [3:0] opcode,
    output logic [2:0] alu_code,
    output logic       a_ce,
    output logic       cy_ce,
    output logic       ci_sel,
    output logic       halt,
    output jump_t      jump
);
    always_comb begin
        alu_code = ALU_ADD;
        a_ce     = 1'b0;
        cy_ce    = 1'b0;
        ci_sel   = 1'b0;
        halt     = 1'b0;
        jump     = J_NONE;
        case (opcode)
            OP_ADD: begin alu_code = ALU_ADD; a_ce = 1'b1; cy_ce = 1'b1; end
            OP_SUB: begin alu_code = ALU_SUB; a_ce = 1'b1; cy_ce = 1'b1; end
            OP_AND: begin alu_code = ALU_AND; a_ce = 1'b1; end
            OP_OR:  begin alu_code = ALU_OR;  a_ce = 1'b1; end
            OP_XOR: begin alu_code = ALU_XOR; a_ce = 1'b1; end
            OP_NOT: begin alu_code = ALU_NOT; a_ce = 1'b1; end
            OP_LD:  begin alu_code = ALU_LD;  a_ce = 1'b1; end
            // Carry-chained forms reuse the plain ALU codes with Ci taken from CY
            OP_ADC: begin alu_code = ALU_ADD; a_ce = 1'b1; cy_ce = 1'b1; ci_sel = 1'b1; end
            OP_SBC: begin alu_code = ALU_SUB; a_ce = 1'b1; cy_ce = 1'b1; ci_sel = 1'b1; end
            OP_JMP:  jump = J_ALWAYS;
            OP_JC:   jump = J_CARRY;
            OP_JZ:   jump = J_ZERO;
            OP_HALT: halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - two-cycle fetch/execute sequencer driving the ALU/accumulator datapath
module ctrl_seq import ctrl_pkg::*, alu_pkg::*; #(
    parameter int PC_W = 8
) (
    input  logic       clk,
    input  logic       Reset,
    ctrl_seq_if.master bus
);
    state_t          state_q, state_n;
    logic [PC_W-1:0] pc_q, pc_n;

    logic [2:0] dec_alu_code;
    logic       dec_a_ce, dec_cy_ce, dec_ci_sel, dec_halt;
    jump_t      dec_jump;
    logic       take;

    ctrl_decode u_decode (
        .opcode   (opcode_of(bus.Instr)),
        .alu_code (dec_alu_code),
        .a_ce     (dec_a_ce),
        .cy_ce    (dec_cy_ce),
        .ci_sel   (dec_ci_sel),
        .halt     (dec_halt),
        .jump     (dec_jump)
    );

    always_comb begin
        case (dec_jump)
            J_ALWAYS: take = 1'b1;
            J_CARRY:  take = bus.CY;
            J_ZERO:   take = bus.A_zero;
            default:  take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        bus.ALUCode = ALU_ADD;
        bus.R       = 8'h00;
        bus.Ci      = 1'b0;
        bus.A_CE    = 1'b0;
        bus.CY_CE   = 1'b0;
        case (state_q)
            FETCH: if (!bus.Stall) state_n = EXEC;
            EXEC: begin
                bus.ALUCode = dec_alu_code;
                bus.R       = bus.Instr[7:0];
                bus.Ci      = dec_ci_sel & bus.CY;
                // A reset landing on this edge discards the pending register writes
                bus.A_CE    = dec_a_ce  & ~Reset;
                bus.CY_CE   = dec_cy_ce & ~Reset;
                if (dec_halt) begin
                    state_n = HALTED;
                end else begin
                    state_n = FETCH;
                    pc_n    = take ? bus.Instr[PC_W-1:0] : pc_q + PC_W'(1);
                end
            end
            HALTED: ;
            default: state_n = FETCH;
        endcase
    end

    assign bus.PC     = pc_q;
    assign bus.Halted = (state_q == HALTED);
endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed bench: ctrl_seq with ROM, ALU, accumulator and carry models
module tb_ctrl_seq;
    import ctrl_pkg::*;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_seq_if #(.PC_W(8)) bus ();
    ctrl_seq #(.PC_W(8)) dut (.clk(clk), .Reset(Reset), .bus(bus));

    logic [11:0] rom [0:255];
    logic [7:0]  acc = 8'h00;
    logic        cy = 1'b0;
    logic [7:0]  alu_y;
    logic        alu_c;
    int a_cnt = 0, cy_cnt = 0, a0 = 0, c0 = 0;
    int errors = 0, checks = 0;

    always @(posedge clk) bus.Instr <= rom[bus.PC];
    assign bus.CY     = cy;
    assign bus.A_zero = (acc == 8'h00);

    always_comb begin
        alu_y = acc;
        alu_c = cy;
        case (bus.ALUCode)
            ALU_ADD: {alu_c, alu_y} = {1'b0, acc} + {1'b0, bus.R} + {8'h00, bus.Ci};
            ALU_SUB: {alu_c, alu_y} = {1'b0, acc} - {1'b0, bus.R} - {8'h00, bus.Ci};
            ALU_AND: alu_y = acc & bus.R;
            ALU_OR:  alu_y = acc | bus.R;
            ALU_XOR: alu_y = acc ^ bus.R;
            ALU_NOT: alu_y = ~acc;
            ALU_LD:  alu_y = bus.R;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (bus.A_CE) begin acc <= alu_y; a_cnt <= a_cnt + 1; end
        if (bus.CY_CE) begin cy <= alu_c; cy_cnt <= cy_cnt + 1; end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom(input logic [11:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic start;
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
        a0 = a_cnt;
        c0 = cy_cnt;
    endtask

    task automatic test_reset;
        bus.Stall = 1'b0;
        clear_rom(12'h05A);
        Reset = 1'b1;
        step(2);
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", bus.PC); end
        checks++; if (bus.A_CE !== 1'b0) begin errors++; $display("FAIL reset_a_ce: got %b expected 0", bus.A_CE); end
        checks++; if (bus.Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", bus.Halted); end
        checks++; if (bus.ALUCode !== ALU_ADD) begin errors++; $display("FAIL reset_alucode: got %h expected %h", bus.ALUCode, ALU_ADD); end
        checks++; if (bus.R !== 8'h00) begin errors++; $display("FAIL reset_r: got %h expected 00", bus.R); end
        Reset = 1'b0;
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL nop_pc0: got %h expected 00", bus.PC); end
        step(1);
        checks++; if (bus.R !== 8'h5A || bus.A_CE !== 1'b0) begin errors++; $display("FAIL nop_exec: R=%h A_CE=%b expected R=5a A_CE=0", bus.R, bus.A_CE); end
        step(1);
        checks++; if (bus.PC !== 8'h01) begin errors++; $display("FAIL nop_pc1: got %h expected 01", bus.PC); end
        step(2);
        checks++; if (bus.PC !== 8'h02) begin errors++; $display("FAIL nop_pc2: got %h expected 02", bus.PC); end
    endtask

    task automatic test_alu;
        clear_rom(12'h000);
        rom[0] = 12'h704; rom[1] = 12'h104; rom[2] = 12'h208; rom[3] = 12'hF00;
        start;
        step(1);
        checks++; if (bus.A_CE !== 1'b1 || bus.CY_CE !== 1'b0 || bus.ALUCode !== ALU_LD || bus.R !== 8'h04) begin
            errors++; $display("FAIL ld_exec: A_CE=%b CY_CE=%b ALU=%h R=%h expected 1 0 %h 04", bus.A_CE, bus.CY_CE, bus.ALUCode, ALU_LD, bus.R);
        end
        step(1);
        checks++; if (acc !== 8'h04 || bus.PC !== 8'h01) begin errors++; $display("FAIL ld_result: acc=%h PC=%h expected 04 01", acc, bus.PC); end
        step(1);
        checks++; if (bus.CY_CE !== 1'b1 || bus.Ci !== 1'b0) begin errors++; $display("FAIL add_exec: CY_CE=%b Ci=%b expected 1 0", bus.CY_CE, bus.Ci); end
        step(1);
        checks++; if (acc !== 8'h08) begin errors++; $display("FAIL add_result: got %h expected 08", acc); end
        step(2);
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL sub_result: got %h expected 00", acc); end
        step(2);
        checks++; if (bus.Halted !== 1'b1 || bus.PC !== 8'h03) begin errors++; $display("FAIL alu_halt: Halted=%b PC=%h expected 1 03", bus.Halted, bus.PC); end
        checks++; if (a_cnt - a0 !== 3 || cy_cnt - c0 !== 2) begin errors++; $display("FAIL alu_pulses: A_CE=%0d CY_CE=%0d expected 3 2", a_cnt - a0, cy_cnt - c0); end
    endtask

    task automatic test_carry;
        clear_rom(12'h000);
        rom[0] = 12'h7FF; rom[1] = 12'h101; rom[2] = 12'hB20; rom[8'h20] = 12'h800; rom[8'h21] = 12'hF00;
        start;
        step(4);
        checks++; if (acc !== 8'h00 || cy !== 1'b1) begin errors++; $display("FAIL add_carry: acc=%h cy=%b expected 00 1", acc, cy); end
        step(1);
        checks++; if (bus.A_CE !== 1'b0 || bus.CY_CE !== 1'b0) begin errors++; $display("FAIL jc_no_ce: A_CE=%b CY_CE=%b expected 0 0", bus.A_CE, bus.CY_CE); end
        step(1);
        checks++; if (bus.PC !== 8'h20) begin errors++; $display("FAIL jc_taken: PC=%h expected 20", bus.PC); end
        step(1);
        checks++; if (bus.Ci !== 1'b1 || bus.ALUCode !== ALU_ADD || bus.CY_CE !== 1'b1) begin
            errors++; $display("FAIL adc_exec: Ci=%b ALU=%h CY_CE=%b expected 1 %h 1", bus.Ci, bus.ALUCode, bus.CY_CE, ALU_ADD);
        end
        step(1);
        checks++; if (acc !== 8'h01 || bus.PC !== 8'h21) begin errors++; $display("FAIL adc_result: acc=%h PC=%h expected 01 21", acc, bus.PC); end
    endtask

    task automatic test_jumps;
        clear_rom(12'h000);
        rom[0] = 12'h700; rom[1] = 12'hC10; rom[8'h10] = 12'h705; rom[8'h11] = 12'hC30;
        rom[8'h12] = 12'hAFF; rom[8'hFF] = 12'h000;
        start;
        step(4);
        checks++; if (bus.PC !== 8'h10) begin errors++; $display("FAIL jz_taken: PC=%h expected 10", bus.PC); end
        step(4);
        checks++; if (bus.PC !== 8'h12 || acc !== 8'h05) begin errors++; $display("FAIL jz_not_taken: PC=%h acc=%h expected 12 05", bus.PC, acc); end
        step(2);
        checks++; if (bus.PC !== 8'hFF) begin errors++; $display("FAIL jmp_ff: PC=%h expected ff", bus.PC); end
        step(2);
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL pc_wrap: PC=%h expected 00", bus.PC); end
    endtask

    task automatic test_stall;
        clear_rom(12'h000);
        rom[0] = 12'h733; rom[1] = 12'hF00;
        start;
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (bus.PC !== 8'h00 || bus.A_CE !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: PC=%h A_CE=%b expected 00 0", i, bus.PC, bus.A_CE); end
        end
        bus.Stall = 1'b0;
        step(1);
        checks++; if (bus.A_CE !== 1'b1 || bus.R !== 8'h33) begin errors++; $display("FAIL stall_release: A_CE=%b R=%h expected 1 33", bus.A_CE, bus.R); end
        bus.Stall = 1'b1;
        step(1);
        checks++; if (bus.PC !== 8'h01 || acc !== 8'h33 || a_cnt - a0 !== 1) begin
            errors++; $display("FAIL stall_once: PC=%h acc=%h pulses=%0d expected 01 33 1", bus.PC, acc, a_cnt - a0);
        end
        bus.Stall = 1'b0;
    endtask

    task automatic test_halt;
        clear_rom(12'h000);
        rom[5] = 12'hF00;
        start;
        step(10);
        checks++; if (bus.PC !== 8'h05) begin errors++; $display("FAIL halt_pc5: PC=%h expected 05", bus.PC); end
        step(1);
        checks++; if (bus.Halted !== 1'b0 || bus.A_CE !== 1'b0) begin errors++; $display("FAIL halt_exec: Halted=%b A_CE=%b expected 0 0", bus.Halted, bus.A_CE); end
        step(1);
        bus.Stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus.PC !== 8'h05 || bus.Halted !== 1'b1) begin errors++; $display("FAIL halted_%0d: PC=%h Halted=%b expected 05 1", i, bus.PC, bus.Halted); end
            step(1);
            if (i == 10) bus.Stall = 1'b0;
        end
        checks++; if (a_cnt - a0 !== 0 || cy_cnt - c0 !== 0) begin errors++; $display("FAIL halt_no_ce: A=%0d CY=%0d expected 0 0", a_cnt - a0, cy_cnt - c0); end
    endtask

    task automatic test_reset_mid_exec;
        clear_rom(12'h000);
        rom[0] = 12'h721; rom[1] = 12'h110; rom[2] = 12'hF00;
        start;
        step(2);
        checks++; if (acc !== 8'h21) begin errors++; $display("FAIL pre_reset_acc: got %h expected 21", acc); end
        step(1);
        Reset = 1'b1;
        #1;
        checks++; if (bus.A_CE !== 1'b0 || bus.CY_CE !== 1'b0) begin errors++; $display("FAIL reset_exec_ce: A_CE=%b CY_CE=%b expected 0 0", bus.A_CE, bus.CY_CE); end
        step(1);
        checks++; if (bus.PC !== 8'h00 || acc !== 8'h21 || bus.Halted !== 1'b0) begin
            errors++; $display("FAIL reset_exec_state: PC=%h acc=%h Halted=%b expected 00 21 0", bus.PC, acc, bus.Halted);
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_alu;
        test_carry;
        test_jumps;
        test_stall;
        test_halt;
        test_reset_mid_exec;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
